// File: rtl/pci_phase_tracker.sv
// pci_phase_tracker
//   Follows FRAME#/IRDY#/TRDY#/DEVSEL# (and optionally STOP#) on a PCI bus and
//   reports the current bus phase, counts completed data transfers and wait
//   states, detects master abort by DEVSEL# timeout and classifies how each
//   transaction terminated. All bus inputs are active-low.
//
//   Build option: define PCI_TRACKER_STOP_EN to honour STOP# (retry and
//   disconnect classification). Without it the stop input is ignored.
//
// Ports
//   clk        bus clock, every register updates on the falling edge
//   rst        synchronous active-high reset
//   frame      FRAME#
//   irdy       IRDY#
//   trdy       TRDY#
//   devsel     DEVSEL#
//   stop       STOP#
//   state      current phase (encoding in the table below)
//   data_count transfers in the current/last transaction (wraps)
//   wait_count DATA_WAIT cycles in the current/last transaction (saturates)
//   xfer       one-cycle pulse per completed data transfer
//   done       one-cycle pulse during TURNAROUND
//   term       0 normal, 1 master abort, 2 retry, 3 disconnect
//
// state      | meaning
// IDLE       | bus idle, waiting for FRAME#
// ADDRESS    | address phase, per-transaction counters cleared on exit
// DATA_WAIT  | data phase without a transfer yet (wait state)
// DATA       | a transfer completed on the previous edge
// FINAL      | last transfer done, waiting for IRDY# to release
// TURNAROUND | one idle-bus cycle, done pulses here
// ABORT      | master abort, waiting for FRAME# and IRDY# to release

module pci_phase_tracker #(
  parameter int CNT_W          = 8,
  parameter int WAIT_W         = 4,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame,
  input  logic              irdy,
  input  logic              trdy,
  input  logic              devsel,
  input  logic              stop,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  data_count,
  output logic [WAIT_W-1:0] wait_count,
  output logic              xfer,
  output logic              done,
  output logic [1:0]        term
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDRESS    = 3'd1,
    DATA_WAIT  = 3'd2,
    DATA       = 3'd3,
    FINAL      = 3'd4,
    TURNAROUND = 3'd5,
    ABORT      = 3'd6
  } phase_e;

  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(DEVSEL_TIMEOUT);

  phase_e              state_r, state_nxt;
  logic [CNT_W-1:0]    data_count_nxt;
  logic [WAIT_W-1:0]   wait_count_nxt;
  logic [WAIT_W-1:0]   timer, timer_nxt;
  logic                devsel_seen, devsel_seen_nxt;
  logic                xfer_nxt;
  logic                done_nxt;
  logic [1:0]          term_nxt;
  logic                xfer_cond;
  logic                stop_hit;
  logic                wait_inc;

  assign xfer_cond = ~irdy & ~trdy & ~devsel;

`ifdef PCI_TRACKER_STOP_EN
  // Master abort outranks a target stop.
  assign stop_hit = ~stop & ~devsel & (term != 2'd1);
`else
  logic stop_unused;
  assign stop_unused = stop;
  assign stop_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt       = state_r;
    data_count_nxt  = data_count;
    wait_count_nxt  = wait_count;
    timer_nxt       = timer;
    devsel_seen_nxt = devsel_seen;
    term_nxt        = term;
    xfer_nxt        = 1'b0;
    wait_inc        = 1'b0;

    case (state_r)
      IDLE: begin
        if (!frame) state_nxt = ADDRESS;
      end
      ADDRESS: begin
        state_nxt       = DATA_WAIT;
        data_count_nxt  = '0;
        wait_count_nxt  = '0;
        term_nxt        = 2'd0;
        timer_nxt       = '0;
        devsel_seen_nxt = 1'b0;
      end
      DATA_WAIT, DATA: begin
        // Once DEVSEL# has been seen the timer stays cleared for the rest
        // of the transaction.
        if (!devsel) begin
          devsel_seen_nxt = 1'b1;
          timer_nxt       = '0;
        end
        if (xfer_cond) begin
          data_count_nxt = data_count + CNT_W'(1);
          xfer_nxt       = 1'b1;
          state_nxt      = frame ? FINAL : DATA;
          if (stop_hit) begin
            term_nxt  = 2'd3;
            state_nxt = FINAL;
          end
        end else if (stop_hit) begin
          term_nxt  = (data_count == '0) ? 2'd2 : 2'd3;
          wait_inc  = (state_r == DATA_WAIT);
          state_nxt = FINAL;
        end else if (state_r == DATA) begin
          state_nxt = DATA_WAIT;
        end else if (devsel && !devsel_seen) begin
          timer_nxt = timer + WAIT_W'(1);
          // Abort takes the edge; the wait state is not counted.
          if (timer_nxt == TIMEOUT) begin
            state_nxt = ABORT;
            term_nxt  = 2'd1;
          end else begin
            wait_inc = 1'b1;
          end
        end else begin
          wait_inc = 1'b1;
        end
        if (wait_inc && (wait_count != '1)) wait_count_nxt = wait_count + WAIT_W'(1);
      end
      FINAL: begin
        if (irdy) state_nxt = TURNAROUND;
      end
      ABORT: begin
        if (frame && irdy) state_nxt = TURNAROUND;
      end
      TURNAROUND: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    done_nxt = (state_nxt == TURNAROUND);
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      data_count  <= '0;
      wait_count  <= '0;
      timer       <= '0;
      devsel_seen <= 1'b0;
      xfer        <= 1'b0;
      done        <= 1'b0;
      term        <= 2'd0;
    end else begin
      state_r     <= state_nxt;
      data_count  <= data_count_nxt;
      wait_count  <= wait_count_nxt;
      timer       <= timer_nxt;
      devsel_seen <= devsel_seen_nxt;
      xfer        <= xfer_nxt;
      done        <= done_nxt;
      term        <= term_nxt;
    end
  end

  assign state = state_r;

endmodule

// File: doc/pci_phase_tracker.md
# pci_phase_tracker

Parametrised PCI bus-phase tracker: follows FRAME#/IRDY#/TRDY#/DEVSEL# (and optionally STOP#) on the shared bus and reports the current bus phase. It also counts completed data transfers and wait states, detects master abort by DEVSEL# timeout, and classifies how each transaction terminated. It sits in the controller alongside the initiator/target logic and feeds status and debug registers. All bus inputs are active-low: 0 = asserted.

## Interface
Parameters:
- CNT_W, 8: width of data-transfer counter.
- WAIT_W, 4: width of wait-state counter (saturating).
- DEVSEL_TIMEOUT, 5: DATA_WAIT cycles without DEVSEL# before master abort; legal range 1..2^WAIT_W-1.

Ports:
- clk  in  1  bus clock; all registers update on falling edge.
- rst  in  1  reset, synchronous, active-high.
- frame  in  1  FRAME#, active-low.
- irdy  in  1  IRDY#, active-low.
- trdy  in  1  TRDY#, active-low.
- devsel  in  1  DEVSEL#, active-low.
- stop  in  1  STOP#, active-low; used only with PCI_TRACKER_STOP_EN.
- state  out  3  phase: IDLE=0, ADDRESS=1, DATA_WAIT=2, DATA=3, FINAL=4, TURNAROUND=5, ABORT=6.
- data_count  out  CNT_W  transfers in current/last transaction.
- wait_count  out  WAIT_W  DATA_WAIT cycles in current/last transaction, saturating.
- xfer  out  1  one-cycle pulse per completed data transfer.
- done  out  1  one-cycle pulse at end of transaction.
- term  out  2  termination: 0 normal, 1 master abort, 2 retry, 3 disconnect.

## Operation
- Transfer condition T: irdy=0 & trdy=0 & devsel=0 at a sampling edge.
- IDLE: frame=0 -> ADDRESS. Otherwise stay.
- ADDRESS: unconditionally -> DATA_WAIT. Clear data_count, wait_count, term, and the DEVSEL timer.
- DATA_WAIT and DATA, T true:
  - data_count increments, wrapping modulo 2^CNT_W.
  - xfer pulses.
  - frame=1 -> FINAL; else -> DATA.
- DATA_WAIT, T false:
  - Stay in DATA_WAIT.
  - wait_count increments, saturating at all-ones.
  - If devsel=1, the DEVSEL timer increments. The timer clears once devsel=0 is seen and does not re-arm within the transaction.
  - Timer reaching DEVSEL_TIMEOUT -> ABORT, term=1. This check has priority over a wait-state increment on the same edge.
- DATA, T false -> DATA_WAIT.
- FINAL: irdy=1 -> TURNAROUND.
- ABORT: frame=1 & irdy=1 -> TURNAROUND.
- TURNAROUND: one cycle, then -> IDLE. done=1 during this cycle. frame=0 is ignored here; a new address phase is recognised only from IDLE.
- data_count, wait_count and term hold their final values until the next ADDRESS.
- Unused encoding 7 -> IDLE on the next edge.

## Timing
- All outputs are registered and change only on the falling edge of clk.
- Reset: rst=1 at an edge forces state=IDLE and clears data_count, wait_count, xfer, done, term and the timer. Reset wins over every simultaneous bus event, including mid-transaction.
- Latency:
  - ADDRESS is visible one edge after frame=0 is sampled in IDLE.
  - The minimum single-transfer transaction is ADDRESS, DATA_WAIT, FINAL, TURNAROUND, IDLE.
- xfer is high for exactly the cycle following each edge where T is true.
- done pulses once per transaction, including aborted ones.

## Configuration
- PCI_TRACKER_STOP_EN defined: stop is sampled in DATA_WAIT and DATA only when devsel=0, and only when term is not already 1 (master abort takes priority). On stop=0:
  - With T true: the transfer counts and term=3.
  - With T false: term=2 if data_count=0, else term=3.
  - State -> FINAL in all these cases. FINAL exits on irdy=1 as normal.
- PCI_TRACKER_STOP_EN undefined: the stop input is ignored and term is never 2 or 3.

## Test plan
- Reset mid-DATA with data_count=3: state=0, data_count=0, term=0 on the next edge; no done pulse.
- Burst of 4 with 2 inserted wait states: data_count=4, wait_count=2, four xfer pulses, term=0, then done, then IDLE.
- devsel held 1 after ADDRESS, DEVSEL_TIMEOUT=5: ABORT on the 5th DATA_WAIT edge with term=1 and data_count=0; done after frame=irdy=1.
- CNT_W=2, 5-transfer burst: data_count wraps to 1.
- STOP_EN, stop=0 with devsel=0 and trdy=1 on the first data phase: term=2, FINAL. Same with 2 prior transfers: term=3. Without the macro the same stimulus gives term=0 and no FINAL until frame=1.
- frame=0 held through TURNAROUND: state goes IDLE, then ADDRESS, with one IDLE cycle in between.
